// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_arbiter
// Description : Round-robin arbiter that shares one external signed 8x8
//               booth multiplier between NREQ requesters. One operation is
//               in flight at a time; each operation is granted, issued,
//               allowed to settle, waited on (with timeout) and answered.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   single clock, all flops on posedge
//   rst        in   asynchronous active-low reset
//   req        in   [NREQ]    per-requester request, held until gnt pulses
//   a_in       in   [8*NREQ]  signed 8-bit multiplicands, requester k at [8k+:8]
//   b_in       in   [8*NREQ]  signed 8-bit multipliers, same packing
//   gnt        out  [NREQ]    one-hot 1-cycle grant; operands captured then
//   done       out  [NREQ]    one-hot 1-cycle completion pulse
//   result     out  [16]      signed product, held until the next done
//   res_id     out  [PW]      requester that owns result
//   err        out            set when the operation timed out, held with result
//   mul_m      out  [8]       multiplicand to the shared multiplier
//   mul_r      out  [8]       multiplier operand to the shared multiplier
//   mul_start  out            start pulse to the multiplier
//   mul_ans    in   [16]      multiplier product
//   mul_ready  in             multiplier completion level
// ============================================================================
module mul_arbiter #(
    parameter int NREQ = 4,
    parameter int TMO  = 31,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   a_in,
    input  logic [8*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [15:0]         result,
    output logic [PW-1:0]       res_id,
    output logic                err,
    output logic [7:0]          mul_m,
    output logic [7:0]          mul_r,
    output logic                mul_start,
    input  logic [15:0]         mul_ans,
    input  logic                mul_ready
);

    // Wait counter is just wide enough to reach TMO, so it can never wrap:
    // the timeout fires when it reaches TMO.
    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        BUSY   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   r_res_id;
    logic [7:0]      r_mul_m;
    logic [7:0]      r_mul_r;
    logic [15:0]     r_result;
    logic            r_err;
    logic [CW-1:0]   r_wait_cnt;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [PW-1:0]   w_ptr_next;
    int              w_idx;
    logic [7:0]      w_a_sel;
    logic [7:0]      w_b_sel;
    logic            w_grant_en;
    logic            w_timeout;

    // ------------------------------------------------------------------
    // Round-robin search: first requester at or above r_ptr, modulo NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = PW'(w_idx);
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        w_a_sel = 8'h00;
        w_b_sel = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == w_winner) begin
                w_a_sel = a_in[i*8 +: 8];
                w_b_sel = b_in[i*8 +: 8];
            end
        end
    end

    assign w_ptr_next = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    // The grant is combinational in IDLE so that operand capture, the gnt
    // pulse and the pointer update all belong to the same cycle. Gating with
    // rst keeps gnt low while reset is held; the first grant can therefore
    // only be taken at a posedge that sees rst high.
    assign w_grant_en = rst && (r_state == IDLE) && w_found;

    // Timeout only counts when the real completion has not arrived; a ready
    // on the final wait cycle still wins.
    assign w_timeout  = (r_wait_cnt == CW'(TMO)) && !mul_ready;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and pulse outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        gnt          = '0;
        done         = '0;
        mul_start    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_en) begin
                    gnt[w_winner] = 1'b1;
                    w_next_state  = ISSUE;
                end
            end
            ISSUE: begin
                mul_start    = 1'b1;
                w_next_state = SETTLE;
            end
            SETTLE: begin
                // The multiplier may still be showing ready from the previous
                // operation; this cycle is spent ignoring it.
                w_next_state = BUSY;
            end
            BUSY: begin
                if (mul_ready || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                done[r_res_id] = 1'b1;
                w_next_state   = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_res_id   <= '0;
            r_mul_m    <= 8'h00;
            r_mul_r    <= 8'h00;
            r_result   <= 16'h0000;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            // Operands stay put from the grant until the next grant, so
            // requesters may change a_in/b_in freely once granted.
            if (w_grant_en) begin
                r_mul_m <= w_a_sel;
                r_mul_r <= w_b_sel;
                r_owner <= w_winner;
                r_ptr   <= w_ptr_next;
            end

            if (r_state == SETTLE) begin
                r_wait_cnt <= '0;
            end else if ((r_state == BUSY) && !mul_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            // result/res_id/err change only on BUSY exit, so they are valid
            // in the done cycle and held until the next one.
            if (r_state == BUSY) begin
                if (mul_ready) begin
                    r_result <= mul_ans;
                    r_err    <= 1'b0;
                    r_res_id <= r_owner;
                end else if (w_timeout) begin
                    r_result <= 16'h0000;
                    r_err    <= 1'b1;
                    r_res_id <= r_owner;
                end
            end
        end
    end

    assign mul_m  = r_mul_m;
    assign mul_r  = r_mul_r;
    assign result = r_result;
    assign res_id = r_res_id;
    assign err    = r_err;

endmodule
`default_nettype wire
